rvb_crc_seq: RTL and testbench

//  Upstream sequencer for the rvb_crc iterative CRC core. Accepts crc32.{b,h,w,d} and
//  crc32c.{b,h,w,d} issue packets, decodes them, drives the core's din_* handshake and

---
 rtl/rvb_crc_seq.sv | 170 +++++++++++++++++
 tb/tb_rvb_crc_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_crc_seq.sv
// rvb_crc_seq: issue-side sequencer for the rvb_crc iterative CRC core.
// Decodes crc32/crc32c issue packets into a one-entry input buffer and hands
// legal ops to the core. A two-entry tag FIFO keeps {rd, illegal} in program
// order, so results return in order on the writeback handshake. Illegal
// encodings skip the core and retire from the FIFO with an illegal flag.
module rvb_crc_seq #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [4:0]      in_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal,
    output logic            crc_din_valid,
    input  logic            crc_din_ready,
    output logic [XLEN-1:0] crc_din_rs1,
    output logic            crc_din_insn20,
    output logic            crc_din_insn21,
    output logic            crc_din_insn23,
    input  logic            crc_dout_valid,
    output logic            crc_dout_ready,
    input  logic [XLEN-1:0] crc_dout_rd
);

    // Decoded fields of the incoming instruction word
    logic       dec_legal;
    logic [1:0] dec_size;
    logic       dec_cmode;

    // Input buffer (one entry)
    logic            ibuf_valid_q, ibuf_valid_d;
    logic            ibuf_legal_q, ibuf_legal_d;
    logic [1:0]      ibuf_size_q,  ibuf_size_d;
    logic            ibuf_cmode_q, ibuf_cmode_d;
    logic [XLEN-1:0] ibuf_rs1_q,   ibuf_rs1_d;
    logic [4:0]      ibuf_rd_q,    ibuf_rd_d;

    // Tag FIFO (two entries, in program order)
    logic [1:0][4:0] tag_rd_q,  tag_rd_d;
    logic [1:0]      tag_ill_q, tag_ill_d;
    logic            wr_ptr_q,  wr_ptr_d;
    logic            rd_ptr_q,  rd_ptr_d;
    logic [1:0]      count_q,   count_d;

    // Internal handshake terms
    logic       fifo_full;
    logic       fifo_empty;
    logic       ibuf_fire;
    logic       in_accept;
    logic       wb_fire;
    logic [4:0] head_rd;
    logic       head_ill;

    // Decode the CRC encoding space; the doubleword forms only exist on RV64
    always_comb begin
        dec_size  = in_insn[21:20];
        dec_cmode = in_insn[23];
        dec_legal = (in_insn[6:0] == 7'b0010011) &&
                    (in_insn[14:12] == 3'b001) &&
                    (in_insn[31:25] == 7'b0110000) &&
                    in_insn[24] &&
                    !in_insn[22] &&
                    !((in_insn[21:20] == 2'b11) && (XLEN == 32));
    end

    // Buffer/FIFO handshake terms; a push is refused while full even if the head pops this cycle
    always_comb begin
        fifo_full  = (count_q == 2'd2);
        fifo_empty = (count_q == 2'd0);
        ibuf_fire  = ibuf_valid_q && !fifo_full && (!ibuf_legal_q || crc_din_ready);
        in_accept  = in_valid && (!ibuf_valid_q || ibuf_fire);
        head_rd    = tag_rd_q[rd_ptr_q];
        head_ill   = tag_ill_q[rd_ptr_q];
    end

    // Port outputs; writeback data is forced to zero unless a legal result is actually retiring
    always_comb begin
        in_ready       = !ibuf_valid_q || ibuf_fire;
        crc_din_valid  = ibuf_valid_q && ibuf_legal_q && !fifo_full;
        crc_din_rs1    = ibuf_rs1_q;
        crc_din_insn20 = ibuf_size_q[0];
        crc_din_insn21 = ibuf_size_q[1];
        crc_din_insn23 = ibuf_cmode_q;
        wb_valid       = !fifo_empty && (head_ill || crc_dout_valid);
        wb_rd          = head_rd;
        wb_illegal     = !fifo_empty && head_ill;
        wb_data        = (wb_valid && !head_ill) ? crc_dout_rd : '0;
        crc_dout_ready = !fifo_empty && !head_ill && wb_ready;
        wb_fire        = wb_valid && wb_ready;
    end

    // Input buffer next state: load on accept, otherwise drain when the entry fires
    always_comb begin
        ibuf_valid_d = ibuf_valid_q;
        ibuf_legal_d = ibuf_legal_q;
        ibuf_size_d  = ibuf_size_q;
        ibuf_cmode_d = ibuf_cmode_q;
        ibuf_rs1_d   = ibuf_rs1_q;
        ibuf_rd_d    = ibuf_rd_q;
        if (in_accept) begin
            ibuf_valid_d = 1'b1;
            ibuf_legal_d = dec_legal;
            ibuf_size_d  = dec_size;
            ibuf_cmode_d = dec_cmode;
            ibuf_rs1_d   = in_rs1;
            ibuf_rd_d    = in_rd;
        end else if (ibuf_fire) begin
            ibuf_valid_d = 1'b0;
        end
    end

    // Tag FIFO next state: push on fire, pop on writeback, count tracks full/empty
    always_comb begin
        tag_rd_d  = tag_rd_q;
        tag_ill_d = tag_ill_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (ibuf_fire) begin
            tag_rd_d[wr_ptr_q]  = ibuf_rd_q;
            tag_ill_d[wr_ptr_q] = !ibuf_legal_q;
            wr_ptr_d            = !wr_ptr_q;
        end
        if (wb_fire) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({ibuf_fire, wb_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; FIFO storage is cleared so the head reads zero
    always_ff @(posedge clock) begin
        if (reset) begin
            ibuf_valid_q <= 1'b0;
            ibuf_legal_q <= 1'b0;
            ibuf_size_q  <= 2'b00;
            ibuf_cmode_q <= 1'b0;
            ibuf_rs1_q   <= '0;
            ibuf_rd_q    <= 5'd0;
            tag_rd_q     <= '0;
            tag_ill_q    <= 2'b00;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_legal_q <= ibuf_legal_d;
            ibuf_size_q  <= ibuf_size_d;
            ibuf_cmode_q <= ibuf_cmode_d;
            ibuf_rs1_q   <= ibuf_rs1_d;
            ibuf_rd_q    <= ibuf_rd_d;
            tag_rd_q     <= tag_rd_d;
            tag_ill_q    <= tag_ill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_rvb_crc_seq.sv
// tb_rvb_crc_seq: directed bench for the CRC sequencer. A behavioural CRC core
// sits behind the XLEN=64 instance. The XLEN=32 instance gets only illegal
// traffic, and its core side is tied off.
module tb_rvb_crc_seq;

    localparam logic [31:0] CRC32_B  = 32'h61001013;
    localparam logic [31:0] CRC32_H  = 32'h61101013;
    localparam logic [31:0] CRC32_W  = 32'h61201013;
    localparam logic [31:0] CRC32_D  = 32'h61301013;
    localparam logic [31:0] CRC32C_B = 32'h61801013;
    localparam logic [31:0] BAD_B22  = 32'h61401013;
    localparam logic [31:0] ADDI_NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid64, in_valid32;
    logic [31:0] in_insn;
    logic [63:0] in_rs1;
    logic [4:0]  in_rd;
    logic        wb_ready;

    logic        in_ready64, wb_valid64, wb_illegal64;
    logic [4:0]  wb_rd64;
    logic [63:0] wb_data64;
    logic        din_valid64, din_ready64, i20_64, i21_64, i23_64;
    logic [63:0] din_rs1_64;
    logic        dout_valid64, dout_ready64;
    logic [63:0] dout_rd64;

    logic        in_ready32, wb_valid32, wb_illegal32;
    logic [4:0]  wb_rd32;
    logic [31:0] wb_data32;
    logic        din_valid32, i20_32, i21_32, i23_32, dout_ready32;
    logic [31:0] din_rs1_32;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int din64_fires = 0;
    int din32_cycles = 0;

    logic        core_busy;
    logic [4:0]  core_cnt;
    logic        core_dv;
    logic [63:0] core_res;

    rvb_crc_seq #(.XLEN(64)) dut64 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_insn(in_insn),
        .in_rs1(in_rs1), .in_rd(in_rd),
        .wb_valid(wb_valid64), .wb_ready(wb_ready), .wb_rd(wb_rd64),
        .wb_data(wb_data64), .wb_illegal(wb_illegal64),
        .crc_din_valid(din_valid64), .crc_din_ready(din_ready64),
        .crc_din_rs1(din_rs1_64), .crc_din_insn20(i20_64),
        .crc_din_insn21(i21_64), .crc_din_insn23(i23_64),
        .crc_dout_valid(dout_valid64), .crc_dout_ready(dout_ready64),
        .crc_dout_rd(dout_rd64)
    );

    rvb_crc_seq #(.XLEN(32)) dut32 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_insn(in_insn),
        .in_rs1(in_rs1[31:0]), .in_rd(in_rd),
        .wb_valid(wb_valid32), .wb_ready(wb_ready), .wb_rd(wb_rd32),
        .wb_data(wb_data32), .wb_illegal(wb_illegal32),
        .crc_din_valid(din_valid32), .crc_din_ready(1'b1),
        .crc_din_rs1(din_rs1_32), .crc_din_insn20(i20_32),
        .crc_din_insn21(i21_32), .crc_din_insn23(i23_32),
        .crc_dout_valid(1'b0), .crc_dout_ready(dout_ready32),
        .crc_dout_rd(32'h0)
    );

    // Free-running clock and cycle counter
    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Count core handshakes on the 64-bit side and valid cycles on the 32-bit side
    always @(posedge clock) begin
        if (din_valid64 && din_ready64) din64_fires <= din64_fires + 1;
        if (din_valid32) din32_cycles <= din32_cycles + 1;
    end

    // Reference bitwise reflected CRC as defined for the RISC-V crc32/crc32c ops
    function automatic logic [63:0] crcRef(input logic [63:0] v, input logic [1:0] size,
                                           input logic cm);
        logic [63:0] x;
        logic [63:0] p;
        x = v;
        p = cm ? 64'h0000_0000_82F6_3B78 : 64'h0000_0000_EDB8_8320;
        for (int i = 0; i < (8 << size); i++) begin
            x = x[0] ? ((x >> 1) ^ p) : (x >> 1);
        end
        return x;
    endfunction

    // Behavioural core: one op at a time, busy 2^size cycles, holds result until taken
    always @(posedge clock) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 5'd0;
            core_dv   <= 1'b0;
            core_res  <= 64'd0;
        end else if (din_valid64 && din_ready64) begin
            core_busy <= 1'b1;
            core_cnt  <= 5'd1 << {i21_64, i20_64};
            core_res  <= crcRef(din_rs1_64, {i21_64, i20_64}, i23_64);
        end else if (core_busy) begin
            if (core_cnt == 5'd1) begin
                core_busy <= 1'b0;
                core_dv   <= 1'b1;
            end
            core_cnt <= core_cnt - 5'd1;
        end else if (core_dv && dout_ready64) begin
            core_dv <= 1'b0;
        end
    end

    assign din_ready64  = !core_busy && !core_dv;
    assign dout_valid64 = core_dv;
    assign dout_rd64    = core_dv ? core_res : 64'hA5A5_A5A5_A5A5_A5A5;

    // One comparison point: count it, and on mismatch count and report it
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present a packet from a negedge and return once it has been accepted; in_valid stays high
    task automatic applyStimulus(input bit to32, input logic [31:0] insn,
                                 input logic [63:0] rs1, input logic [4:0] rd,
                                 output int acc);
        int n;
        logic rdy;
        in_insn = insn;
        in_rs1  = rs1;
        in_rd   = rd;
        if (to32) in_valid32 = 1'b1;
        else      in_valid64 = 1'b1;
        n   = 0;
        rdy = to32 ? in_ready32 : in_ready64;
        while (!rdy && n < 50) begin
            @(negedge clock);
            n++;
            rdy = to32 ? in_ready32 : in_ready64;
        end
        checkOutput("issue in_ready", 64'(rdy), 64'd1);
        @(posedge clock);
        @(negedge clock);
        acc = cyc - 1;
    endtask

    // Wait (bounded) for wb_valid on the selected instance, return the cycle it was seen
    task automatic waitWb(input bit to32, output int at);
        int n;
        logic v;
        n = 0;
        v = to32 ? wb_valid32 : wb_valid64;
        while (!v && n < 60) begin
            @(negedge clock);
            n++;
            v = to32 ? wb_valid32 : wb_valid64;
        end
        checkOutput("wb_valid arrives", 64'(v), 64'd1);
        at = cyc;
    endtask

    // Check every reset-state output of the 64-bit instance
    task automatic checkResetOutputs(input string tag);
        $display("[TB] reset state check: %s", tag);
        checkOutput("rst in_ready", 64'(in_ready64), 64'd1);
        checkOutput("rst wb_valid", 64'(wb_valid64), 64'd0);
        checkOutput("rst wb_rd", 64'(wb_rd64), 64'd0);
        checkOutput("rst wb_data", wb_data64, 64'd0);
        checkOutput("rst wb_illegal", 64'(wb_illegal64), 64'd0);
        checkOutput("rst crc_din_valid", 64'(din_valid64), 64'd0);
        checkOutput("rst crc_dout_ready", 64'(dout_ready64), 64'd0);
    endtask

    // Issue one op to the 64-bit instance and check its retirement and latency
    task automatic runOne(input string tag, input logic [31:0] insn, input logic [63:0] rs1,
                          input logic [4:0] rd, input int lat, input logic [63:0] data,
                          input logic ill);
        int acc;
        int at;
        $display("[TB] %s", tag);
        applyStimulus(1'b0, insn, rs1, rd, acc);
        in_valid64 = 1'b0;
        waitWb(1'b0, at);
        checkOutput({tag, " latency"}, 64'(at - acc), 64'(lat));
        checkOutput({tag, " wb_rd"}, 64'(wb_rd64), 64'(rd));
        checkOutput({tag, " wb_data"}, wb_data64, data);
        checkOutput({tag, " wb_illegal"}, 64'(wb_illegal64), 64'(ill));
        @(negedge clock);
        checkOutput({tag, " drained"}, 64'(wb_valid64), 64'd0);
    endtask

    logic [4:0]  exp_rd   [3];
    logic [63:0] exp_data [3];
    logic        exp_ill  [3];

    initial begin
        int acc1, acc2, at1, at2, fires0, good;

        reset      = 1'b1;
        in_valid64 = 1'b0;
        in_valid32 = 1'b0;
        in_insn    = 32'h0;
        in_rs1     = 64'h0;
        in_rd      = 5'd0;
        wb_ready   = 1'b1;
        repeat (3) @(negedge clock);
        checkResetOutputs("power-up");
        checkOutput("rst dut32 in_ready", 64'(in_ready32), 64'd1);
        checkOutput("rst dut32 wb_valid", 64'(wb_valid32), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        runOne("T1 crc32.b", CRC32_B, 64'h01, 5'd5, 3, 64'h7707_3096, 1'b0);
        runOne("T2 crc32c.b", CRC32C_B, 64'h01, 5'd6, 3, 64'hF26B_8303, 1'b0);
        runOne("T2 crc32.h", CRC32_H, 64'h100, 5'd8, 4, 64'h7707_3096, 1'b0);
        runOne("crc32.d", CRC32_D, 64'h0100_0000_0000_0000, 5'd12, 10, 64'h7707_3096, 1'b0);

        fires0 = din64_fires;
        runOne("illegal bit22", BAD_B22, 64'h1234, 5'd3, 2, 64'd0, 1'b1);
        checkOutput("illegal skips core", 64'(din64_fires - fires0), 64'd0);

        $display("[TB] T3 legal then illegal back-to-back");
        applyStimulus(1'b0, CRC32_W, 64'h0100_0000, 5'd9, acc1);
        applyStimulus(1'b0, ADDI_NOP, 64'h0, 5'd7, acc2);
        in_valid64 = 1'b0;
        checkOutput("T3 back-to-back accept", 64'(acc2 - acc1), 64'd1);
        waitWb(1'b0, at1);
        checkOutput("T3 crc latency", 64'(at1 - acc1), 64'd6);
        checkOutput("T3 crc wb_rd", 64'(wb_rd64), 64'd9);
        checkOutput("T3 crc wb_data", wb_data64, 64'h7707_3096);
        checkOutput("T3 crc wb_illegal", 64'(wb_illegal64), 64'd0);
        @(negedge clock);
        waitWb(1'b0, at2);
        checkOutput("T3 illegal follows", 64'(at2 - at1), 64'd1);
        checkOutput("T3 illegal wb_rd", 64'(wb_rd64), 64'd7);
        checkOutput("T3 illegal wb_data", wb_data64, 64'd0);
        checkOutput("T3 illegal wb_illegal", 64'(wb_illegal64), 64'd1);
        @(negedge clock);
        checkOutput("T3 drained", 64'(wb_valid64), 64'd0);

        $display("[TB] T4 XLEN=32 crc32.d is illegal");
        applyStimulus(1'b1, CRC32_D, 64'h5, 5'd4, acc1);
        in_valid32 = 1'b0;
        waitWb(1'b1, at1);
        checkOutput("T4 latency", 64'(at1 - acc1), 64'd2);
        checkOutput("T4 wb_rd", 64'(wb_rd32), 64'd4);
        checkOutput("T4 wb_data", 64'(wb_data32), 64'd0);
        checkOutput("T4 wb_illegal", 64'(wb_illegal32), 64'd1);
        checkOutput("T4 crc_din_valid never", 64'(din32_cycles), 64'd0);
        @(negedge clock);
        checkOutput("T4 drained", 64'(wb_valid32), 64'd0);

        $display("[TB] T5 writeback stall fills the FIFO");
        wb_ready = 1'b0;
        applyStimulus(1'b0, CRC32_B, 64'h01, 5'd1, acc1);
        applyStimulus(1'b0, ADDI_NOP, 64'h0, 5'd2, acc1);
        applyStimulus(1'b0, CRC32C_B, 64'h01, 5'd3, acc1);
        in_valid64 = 1'b0;
        good = 0;
        for (int k = 0; k < 20; k++) begin
            if (wb_valid64 && wb_rd64 == 5'd1 && wb_data64 == 64'h7707_3096 && !wb_illegal64)
                good++;
            @(negedge clock);
        end
        checkOutput("T5 head held stable", 64'(good), 64'd20);
        checkOutput("T5 in_ready low", 64'(in_ready64), 64'd0);
        checkOutput("T5 crc_dout_ready low", 64'(dout_ready64), 64'd0);
        checkOutput("T5 third op not issued", 64'(din_valid64), 64'd0);
        exp_rd[0] = 5'd1; exp_data[0] = 64'h7707_3096; exp_ill[0] = 1'b0;
        exp_rd[1] = 5'd2; exp_data[1] = 64'd0;         exp_ill[1] = 1'b1;
        exp_rd[2] = 5'd3; exp_data[2] = 64'hF26B_8303; exp_ill[2] = 1'b0;
        wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitWb(1'b0, at1);
            checkOutput($sformatf("T5 retire%0d wb_rd", k), 64'(wb_rd64), 64'(exp_rd[k]));
            checkOutput($sformatf("T5 retire%0d wb_data", k), wb_data64, exp_data[k]);
            checkOutput($sformatf("T5 retire%0d wb_illegal", k), 64'(wb_illegal64),
                        64'(exp_ill[k]));
            @(negedge clock);
        end
        checkOutput("T5 drained", 64'(wb_valid64), 64'd0);
        checkOutput("T5 in_ready back", 64'(in_ready64), 64'd1);

        $display("[TB] T6 reset during crc32.d");
        applyStimulus(1'b0, CRC32_D, 64'hFFFF_0000_1234_5678, 5'd10, acc1);
        in_valid64 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkResetOutputs("mid-CRC");
        reset = 1'b0;
        @(negedge clock);
        checkOutput("T6 no stale retire", 64'(wb_valid64), 64'd0);
        runOne("T6 crc32.b zero", CRC32_B, 64'h0, 5'd11, 3, 64'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
